// File: rtl/ps2_host_rx_pkg.sv
// ps2_host_rx_pkg: shared widths, rx state encoding, frame constants and defaults for the PS/2 receiver.
package ps2_host_rx_pkg;
  localparam int DATA_W = 8;
  localparam int TCNT_W = 16;
  localparam int FCNT_W = 4;
  localparam int DEF_FILTER_LENGTH = 8;
  localparam int DEF_TIMEOUT_CYCLES = 5000;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3} rx_state_t;
  function automatic logic odd_parity_ok(input logic [DATA_W-1:0] b, input logic p);
    return ^{b, p};
  endfunction
endpackage

// File: rtl/ps2_host_rx_if.sv
// ps2_host_rx_if: received-byte result bundle with its error flags.
interface ps2_host_rx_if;
  import ps2_host_rx_pkg::*;
  logic valid;
  logic [DATA_W-1:0] data;
  logic parity_error;
  logic protocol_error;
  logic timeout;
  modport master (output valid, data, parity_error, protocol_error, timeout);
  modport slave (input valid, data, parity_error, protocol_error, timeout);
endinterface

// File: rtl/ps2_host_rx_clk_filter.sv
// ps2_clk_filter: synchronises and de-glitches the PS/2 clock, strobing fall on a filtered 1->0 change.
module ps2_clk_filter
  import ps2_host_rx_pkg::*;
#(
  parameter int FILTER_LENGTH = DEF_FILTER_LENGTH
) (
  input  logic clk,
  input  logic clk__enable,
  input  logic reset,
  input  logic raw,
  output logic fall
);
  localparam logic [FCNT_W-1:0] CNT_MAX = FCNT_W'(FILTER_LENGTH - 1);
  logic [1:0] sync_q;
  logic filt_q;
  logic [FCNT_W-1:0] cnt_q;
  logic flip;
  assign flip = (sync_q[1] != filt_q) && (cnt_q == CNT_MAX);
  assign fall = clk__enable && flip && filt_q;
  always_ff @(posedge clk)
    if (reset) begin
      sync_q <= '1;
      filt_q <= 1'b1;
      cnt_q <= '0;
    end else if (clk__enable) begin
      sync_q <= {sync_q[0], raw};
      filt_q <= flip ? sync_q[1] : filt_q;
      cnt_q <= (sync_q[1] == filt_q || flip) ? '0 : cnt_q + 1'b1;
    end
endmodule

// File: rtl/ps2_host_rx.sv
// ps2_host_rx: PS/2 device-to-host frame receiver; PS2_HOST_RX_ERROR_COUNT_EN adds a saturating error counter.
module ps2_host_rx
  import ps2_host_rx_pkg::*;
#(
  parameter int FILTER_LENGTH = DEF_FILTER_LENGTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic clk__enable,
  input  logic reset,
  input  logic ps2_in__clk,
  input  logic ps2_in__data,
`ifdef PS2_HOST_RX_ERROR_COUNT_EN
  output logic [7:0] rx_error_count,
`endif
  ps2_host_rx_if.master ps2_rx_data
);
  localparam logic [TCNT_W-1:0] TO_MAX = TCNT_W'(TIMEOUT_CYCLES);
  rx_state_t state_q, state_d;
  logic fall, emit, expire, take, din;
  logic [1:0] dsync_q;
  logic [DATA_W-1:0] shift_q;
  logic [2:0] bcnt_q;
  logic parity_ok_q;
  logic [TCNT_W-1:0] tcnt_q;
  ps2_clk_filter #(.FILTER_LENGTH(FILTER_LENGTH)) u_clk_filter (
    .clk(clk),
    .clk__enable(clk__enable),
    .reset(reset),
    .raw(ps2_in__clk),
    .fall(fall)
  );
  assign din = dsync_q[1];
  assign expire = state_q != IDLE && tcnt_q == TO_MAX;
  // A timeout in the same cycle as a fall discards the fall.
  assign take = fall && !expire;
  always_comb begin
    state_d = state_q;
    emit = expire;
    if (expire) state_d = IDLE;
    else if (fall)
      case (state_q)
        IDLE:    state_d = din == START_BIT ? DATA : IDLE;
        DATA:    state_d = &bcnt_q ? PARITY : DATA;
        PARITY:  state_d = STOP;
        default: begin
          state_d = IDLE;
          emit = 1'b1;
        end
      endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      dsync_q <= '1;
      shift_q <= '0;
      bcnt_q <= '0;
      parity_ok_q <= 1'b0;
      tcnt_q <= '0;
      ps2_rx_data.valid <= 1'b0;
      ps2_rx_data.data <= '0;
      ps2_rx_data.parity_error <= 1'b0;
      ps2_rx_data.protocol_error <= 1'b0;
      ps2_rx_data.timeout <= 1'b0;
    end else if (clk__enable) begin
      state_q <= state_d;
      dsync_q <= {dsync_q[0], ps2_in__data};
      tcnt_q <= (fall || expire || state_q == IDLE) ? '0 : tcnt_q + 1'b1;
      if (take && state_q == IDLE) bcnt_q <= '0;
      if (take && state_q == DATA) begin
        shift_q <= {din, shift_q[DATA_W-1:1]};
        bcnt_q <= bcnt_q + 1'b1;
      end
      if (take && state_q == PARITY) parity_ok_q <= odd_parity_ok(shift_q, din);
      ps2_rx_data.valid <= emit;
      if (emit) begin
        ps2_rx_data.data <= expire ? '0 : shift_q;
        ps2_rx_data.parity_error <= !expire && !parity_ok_q;
        ps2_rx_data.protocol_error <= !expire && din != STOP_BIT;
        ps2_rx_data.timeout <= expire;
      end
    end
`ifdef PS2_HOST_RX_ERROR_COUNT_EN
  logic err;
  assign err = emit && (expire || !parity_ok_q || din != STOP_BIT);
  always_ff @(posedge clk)
    if (reset) rx_error_count <= '0;
    else if (clk__enable && err && !(&rx_error_count)) rx_error_count <= rx_error_count + 1'b1;
`endif
endmodule

// File: tb/tb_ps2_host_rx.sv
// tb_ps2_host_rx: directed frames with hand-computed results for the PS/2 receiver.
module tb_ps2_host_rx;
  logic clk = 1'b0;
  logic clk__enable = 1'b1;
  logic reset = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_dat = 1'b1;
  int checks = 0, errors = 0, cyc = 0, vcount = 0, last_fall = 0, v_cyc = 0, half = 400, n = 0;
  logic [7:0] v_data;
  logic v_perr, v_prot, v_to;
`ifdef PS2_HOST_RX_ERROR_COUNT_EN
  logic [7:0] err_cnt;
`endif
  ps2_host_rx_if rx ();
  ps2_host_rx #(.FILTER_LENGTH(8), .TIMEOUT_CYCLES(2000)) dut (
`ifdef PS2_HOST_RX_ERROR_COUNT_EN
    .rx_error_count(err_cnt),
`endif
    .clk(clk),
    .clk__enable(clk__enable),
    .reset(reset),
    .ps2_in__clk(ps2_clk),
    .ps2_in__data(ps2_dat),
    .ps2_rx_data(rx)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk)
    if (rx.valid) begin
      vcount++;
      v_cyc = cyc;
      v_data = rx.data;
      v_perr = rx.parity_error;
      v_prot = rx.protocol_error;
      v_to = rx.timeout;
    end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask
  task automatic send_bit(input logic b);
    ps2_dat = b;
    tick(half);
    ps2_clk = 1'b0;
    last_fall = cyc;
    tick(half);
    ps2_clk = 1'b1;
  endtask
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp,
                            input int nbits = 11, input int pause_at = -1, input int pause_len = 0);
    logic [10:0] f;
    f = {stp, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      send_bit(f[i]);
      if (i == pause_at) begin
        clk__enable = 1'b0;
        tick(pause_len);
        clk__enable = 1'b1;
      end
    end
    ps2_dat = 1'b1;
    tick(half);
  endtask
  task automatic expect_frame(input string tag, input int n0, input logic [7:0] d,
                              input logic pe, input logic pr, input logic to);
    check({tag, "_count"}, vcount - n0, 1);
    check({tag, "_data"}, v_data, d);
    check({tag, "_perr"}, v_perr, pe);
    check({tag, "_prot"}, v_prot, pr);
    check({tag, "_tmo"}, v_to, to);
  endtask
  initial begin
    tick(3);
    check("rst_valid", rx.valid, 0);
    check("rst_data", rx.data, 0);
    check("rst_perr", rx.parity_error, 0);
    check("rst_prot", rx.protocol_error, 0);
    check("rst_tmo", rx.timeout, 0);
    reset = 1'b0;
    tick(5);
    n = vcount;
    send_frame(8'h1C, 1'b0, 1'b1);
    expect_frame("clean", n, 8'h1C, 0, 0, 0);
    half = 100;
    n = vcount;
    send_frame(8'h1C, 1'b1, 1'b1);
    expect_frame("parity", n, 8'h1C, 1, 0, 0);
    n = vcount;
    send_frame(8'hF0, 1'b1, 1'b0);
    expect_frame("stop", n, 8'hF0, 0, 1, 0);
    half = 400;
    n = vcount;
    send_frame(8'hA5, 1'b0, 1'b1, 6);
    for (int i = 0; i < 3000 && vcount == n; i++) tick(1);
    expect_frame("timeout", n, 8'h00, 0, 0, 1);
    check("timeout_latency", v_cyc - last_fall, 2011);
    half = 100;
    n = vcount;
    send_frame(8'hE0, 1'b0, 1'b1);
    expect_frame("after_tmo", n, 8'hE0, 0, 0, 0);
    n = vcount;
    ps2_dat = 1'b0;
    tick(20);
    ps2_clk = 1'b0;
    tick(3);
    ps2_clk = 1'b1;
    tick(50);
    ps2_dat = 1'b1;
    tick(20);
    check("glitch_none", vcount - n, 0);
    send_frame(8'h5A, 1'b1, 1'b1);
    expect_frame("glitch", n, 8'h5A, 0, 0, 0);
    n = vcount;
    send_frame(8'h33, 1'b1, 1'b1, 5);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(20);
    check("midrst_none", vcount - n, 0);
    send_frame(8'h12, 1'b1, 1'b1);
    expect_frame("midrst", n, 8'h12, 0, 0, 0);
    half = 400;
    n = vcount;
    send_frame(8'h29, 1'b0, 1'b1, 11, 3, 1500);
    expect_frame("enable", n, 8'h29, 0, 0, 0);
`ifdef PS2_HOST_RX_ERROR_COUNT_EN
    half = 10;
    for (int i = 0; i < 300; i++) send_frame(8'h00, 1'b0, 1'b1);
    check("err_cnt_sat", err_cnt, 8'hFF);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
